// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the MEM stage (cpu)
// and a debug/loader requester (dbg). cpu has fixed priority and passes straight through
// with zero latency. dbg uses req/gnt with a response registered one cycle after the grant.
// A starvation guard forces one dbg slot, stalling the pipeline for that cycle, once dbg has
// been blocked for MAX_WAIT consecutive cycles.
//
// Ports:
//   clk, rst                        clock; synchronous active-high reset
//   cpu_rd_en/wr_en/addr/wr_data    MEM-stage access, cpu_rd_data returns load data (comb)
//   cpu_stall                       hold the MEM stage this cycle (forced dbg slot)
//   dbg_req/we/addr/wr_data         dbg request, held stable until dbg_gnt
//   dbg_gnt                         dbg owns the port this cycle
//   dbg_rsp_valid/rsp_data          one-cycle response pulse after each grant (0 data for writes)
//   mem_*                           data_mem port, combinational read via mem_rd_data
//   stat_cpu/dbg/force_cnt          access counters, present only when ARB_STATS_EN is defined,
//                                   otherwise tied to 0
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 64,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  output logic              dbg_gnt,
  output logic              dbg_rsp_valid,
  output logic [DATA_W-1:0] dbg_rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [31:0]       stat_cpu_cnt,
  output logic [31:0]       stat_dbg_cnt,
  output logic [31:0]       stat_force_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  localparam logic [7:0] WAIT_MAX  = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [1:0] state, state_nxt;
  logic [7:0] wait_cnt;
  logic       in_force, cpu_act, own_cpu, own_dbg, blocked;

  assign in_force = (state == ST_FORCE);
  assign cpu_act  = cpu_rd_en | cpu_wr_en;

  // Ownership is suppressed during reset so no stray write reaches data_mem.
  // In FORCE a dropped dbg_req leaves the slot empty; the cpu still stalls.
  assign own_cpu = !rst && !in_force && cpu_act;
  assign own_dbg = !rst && dbg_req && (in_force || !cpu_act);
  assign blocked = dbg_req && !own_dbg;

  assign dbg_gnt   = own_dbg;
  assign cpu_stall = in_force;

  // Port mux
  assign mem_addr    = own_dbg ? dbg_addr    : cpu_addr;
  assign mem_wr_data = own_dbg ? dbg_wr_data : cpu_wr_data;
  assign mem_wr_en   = own_cpu ? cpu_wr_en   : (own_dbg && dbg_we);
  assign mem_rd_en   = own_cpu ? cpu_rd_en   : (own_dbg && !dbg_we);
  assign cpu_rd_data = own_cpu ? mem_rd_data : '0;

  // wait_cnt only leaves 0 while a request stays blocked, so IDLE always sees 0 and
  // can go straight to FORCE when MAX_WAIT is 1.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (blocked) state_nxt = (wait_cnt == WAIT_LAST) ? ST_FORCE : ST_WAIT;
      ST_WAIT:  if (!blocked)                   state_nxt = ST_IDLE;
                else if (wait_cnt == WAIT_LAST) state_nxt = ST_FORCE;
      ST_FORCE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!blocked)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Response captured at the grant edge; writes answer with 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_rsp_valid <= 1'b0;
      dbg_rsp_data  <= '0;
    end else begin
      dbg_rsp_valid <= own_dbg;
      if (own_dbg)
        dbg_rsp_data <= dbg_we ? '0 : mem_rd_data;
    end
  end

`ifdef ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cpu_cnt   <= '0;
      stat_dbg_cnt   <= '0;
      stat_force_cnt <= '0;
    end else begin
      if (own_cpu)  stat_cpu_cnt   <= stat_cpu_cnt + 32'd1;
      if (own_dbg)  stat_dbg_cnt   <= stat_dbg_cnt + 32'd1;
      if (in_force) stat_force_cnt <= stat_force_cnt + 32'd1;
    end
  end
`else
  assign stat_cpu_cnt   = '0;
  assign stat_dbg_cnt   = '0;
  assign stat_force_cnt = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_rd_en, cpu_wr_en;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wr_data, cpu_rd_data;
  logic          cpu_stall;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rsp_valid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wr_data, dbg_rsp_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic          mem_wr_en, mem_rd_en;
  logic [31:0]   stat_cpu_cnt, stat_dbg_cnt, stat_force_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
    .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wr_data(dbg_wr_data),
    .dbg_gnt(dbg_gnt), .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_data(dbg_rsp_data),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .stat_cpu_cnt(stat_cpu_cnt), .stat_dbg_cnt(stat_dbg_cnt), .stat_force_cnt(stat_force_cnt)
  );

  // Environment memory: 256 words, combinational read, write at posedge.
  function automatic logic [63:0] init_val(input logic [7:0] a);
    return 64'hC0DE_0000_0000_0000 | (64'(a) * 64'h0001_0003_0007);
  endfunction

  logic [63:0] env_mem [256];
  logic        env_wr  [256] = '{default: 1'b0};

  always @(posedge clk) begin
    if (mem_wr_en) begin
      env_mem[mem_addr[7:0]] <= mem_wr_data;
      env_wr[mem_addr[7:0]]  <= 1'b1;
    end
  end
  assign mem_rd_data = env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);

  // Reference model state
  logic [63:0] ref_mem [256];
  bit          m_force, m_rv, m_gnt;
  int          m_streak;
  logic [63:0] m_rd;
  logic [31:0] m_cpu, m_dbg, m_frc;
  // DUT values sampled mid-cycle by the last step
  logic        s_gnt, s_stall, s_wr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats();
`ifdef ARB_STATS_EN
    chk("stat_cpu_cnt", stat_cpu_cnt, m_cpu);
    chk("stat_dbg_cnt", stat_dbg_cnt, m_dbg);
    chk("stat_force_cnt", stat_force_cnt, m_frc);
`else
    chk("stat_cpu_cnt_off", stat_cpu_cnt, 0);
    chk("stat_dbg_cnt_off", stat_dbg_cnt, 0);
    chk("stat_force_cnt_off", stat_force_cnt, 0);
`endif
  endtask

  task automatic idle();
    cpu_rd_en = 0; cpu_wr_en = 0; cpu_addr = '0; cpu_wr_data = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wr_data = '0;
  endtask

  // One clock cycle: inputs already applied; check combinational outputs mid-cycle
  // against the ownership rules, then registered outputs just after the edge.
  task automatic step();
    logic        act, oc, od, blk, nf;
    logic [7:0]  ca, da;
    @(negedge clk);
    act = cpu_rd_en | cpu_wr_en;
    oc  = !m_force && act;
    od  = dbg_req && (m_force || !act);
    ca  = cpu_addr[7:0];
    da  = dbg_addr[7:0];
    s_gnt = dbg_gnt; s_stall = cpu_stall; s_wr = mem_wr_en;
    chk("dbg_gnt", dbg_gnt, od);
    chk("cpu_stall", cpu_stall, m_force);
    chk("cpu_rd_data", cpu_rd_data, oc ? ref_mem[ca] : 64'd0);
    if (oc) begin
      chk("cpu_mem_addr", mem_addr, cpu_addr);
      chk("cpu_mem_wr_en", mem_wr_en, cpu_wr_en);
      chk("cpu_mem_rd_en", mem_rd_en, cpu_rd_en);
      if (cpu_wr_en) chk("cpu_mem_wr_data", mem_wr_data, cpu_wr_data);
    end else if (od) begin
      chk("dbg_mem_addr", mem_addr, dbg_addr);
      chk("dbg_mem_wr_en", mem_wr_en, dbg_we);
      chk("dbg_mem_rd_en", mem_rd_en, !dbg_we);
      if (dbg_we) chk("dbg_mem_wr_data", mem_wr_data, dbg_wr_data);
    end else begin
      chk("none_mem_wr_en", mem_wr_en, 0);
      chk("none_mem_rd_en", mem_rd_en, 0);
    end
    // Model: response, memory, starvation streak, stats
    if (od) m_rd = dbg_we ? 64'd0 : ref_mem[da];
    if (oc && cpu_wr_en) ref_mem[ca] = cpu_wr_data;
    if (od && dbg_we)    ref_mem[da] = dbg_wr_data;
    blk = dbg_req && !od;
    m_streak = blk ? m_streak + 1 : 0;
    nf = blk && (m_streak >= MW);
    m_cpu += 32'(oc);
    m_dbg += 32'(od);
    m_frc += 32'(m_force);
    @(posedge clk); #1;
    m_force = nf; m_rv = od; m_gnt = od;
    chk("dbg_rsp_valid", dbg_rsp_valid, m_rv);
    if (m_rv) chk("dbg_rsp_data", dbg_rsp_data, m_rd);
    chk_stats();
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_mem_wr_en", mem_wr_en, 0);
    chk("rst_mem_rd_en", mem_rd_en, 0);
    @(posedge clk); #1;
    rst = 0;
    m_force = 0; m_rv = 0; m_gnt = 0; m_streak = 0; m_rd = '0;
    m_cpu = '0; m_dbg = '0; m_frc = '0;
    chk("rst_cpu_stall", cpu_stall, 0);
    chk("rst_rsp_valid", dbg_rsp_valid, 0);
    chk("rst_rsp_data", dbg_rsp_data, 0);
    chk("rst_stat_cpu", stat_cpu_cnt, 0);
    chk("rst_stat_dbg", stat_dbg_cnt, 0);
    chk("rst_stat_force", stat_force_cnt, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    idle();
    // Reset with both requesters active: enables and grant must stay low
    cpu_wr_en = 1; cpu_addr = 32'h4; cpu_wr_data = 64'hDEAD; dbg_req = 1;
    do_reset();

    // Store 0xAB at 0x10, then isolated dbg read of it
    idle(); cpu_wr_en = 1; cpu_addr = 32'h10; cpu_wr_data = 64'hAB; step();
    idle(); dbg_req = 1; dbg_we = 0; dbg_addr = 32'h10; step();
    chk("iso_gnt", s_gnt, 1);
    chk("iso_rsp_valid", dbg_rsp_valid, 1);
    chk("iso_rsp_data", dbg_rsp_data, 64'hAB);
    idle(); step();

    // cpu priority: three blocked cycles, grant on the fourth
    idle(); dbg_req = 1; dbg_we = 0; dbg_addr = 32'h30;
    for (int c = 0; c < 3; c++) begin
      cpu_wr_en = 1; cpu_addr = 32'h8; cpu_wr_data = {$urandom, $urandom};
      step();
      chk("prio_gnt_blocked", s_gnt, 0);
      chk("prio_no_stall", s_stall, 0);
    end
    cpu_wr_en = 0; step();
    chk("prio_gnt_cycle4", s_gnt, 1);
    idle(); step();

    // Starvation guard: MW blocked cycles, then a forced slot with stall
    idle(); dbg_req = 1; dbg_we = 1; dbg_addr = 32'h40; dbg_wr_data = 64'h5555;
    for (int c = 0; c < MW; c++) begin
      cpu_rd_en = 1; cpu_addr = 32'($urandom_range(0, 255));
      step();
      chk("starve_blocked", s_gnt, 0);
      chk("starve_no_stall", s_stall, 0);
    end
    step();
    chk("starve_force_gnt", s_gnt, 1);
    chk("starve_force_stall", s_stall, 1);
    dbg_req = 0; step();
    chk("starve_resume_stall", s_stall, 0);
`ifdef ARB_STATS_EN
    chk("starve_force_cnt", stat_force_cnt, 1);
`else
    chk("starve_force_cnt_off", stat_force_cnt, 0);
`endif
    idle(); step();

    // dbg write then read of 0x20, back-to-back grants
    idle(); dbg_req = 1; dbg_we = 1; dbg_addr = 32'h20; dbg_wr_data = 64'h1234; step();
    chk("wr_gnt", s_gnt, 1);
    chk("wr_rsp_valid", dbg_rsp_valid, 1);
    chk("wr_rsp_data", dbg_rsp_data, 0);
    dbg_we = 0; dbg_wr_data = '0; step();
    chk("rd_gnt", s_gnt, 1);
    chk("rd_rsp_valid", dbg_rsp_valid, 1);
    chk("rd_rsp_data", dbg_rsp_data, 64'h1234);
    idle(); step();

    // dbg_req dropped during the forced slot: empty slot, cpu still stalled
    idle(); dbg_req = 1; dbg_we = 0; dbg_addr = 32'h50;
    for (int c = 0; c < MW; c++) begin
      cpu_wr_en = 1; cpu_addr = 32'($urandom_range(0, 255)); cpu_wr_data = {$urandom, $urandom};
      step();
    end
    dbg_req = 0; step();
    chk("viol_gnt", s_gnt, 0);
    chk("viol_stall", s_stall, 1);
    chk("viol_wr_en", s_wr, 0);
    chk("viol_no_rsp", dbg_rsp_valid, 0);
    idle(); step();

    // Reset while in FORCE
    idle(); dbg_req = 1; dbg_we = 0; dbg_addr = 32'h60;
    for (int c = 0; c < MW; c++) begin
      cpu_rd_en = 1; cpu_addr = 32'($urandom_range(0, 255));
      step();
    end
    chk("pre_rst_in_force", cpu_stall, 1);
    do_reset();
    step(); step();
    idle(); step();

    // Randomized traffic, protocol-legal, checked cycle by cycle
    for (int n = 0; n < 1500; n++) begin
      if (!m_force) begin
        int r;
        r = $urandom_range(0, 99);
        cpu_rd_en = (r < 35);
        cpu_wr_en = (r >= 35) && (r < 70);
        cpu_addr = 32'($urandom_range(0, 15));
        cpu_wr_data = {$urandom, $urandom};
      end
      if (!(dbg_req && !m_gnt)) begin
        dbg_req = ($urandom_range(0, 99) < 40);
        dbg_we = $urandom_range(0, 1) == 1;
        dbg_addr = 32'($urandom_range(0, 15));
        dbg_wr_data = {$urandom, $urandom};
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
